// File: rtl/pipemem_io_gen.sv
// MEM stage: word-addressed data RAM plus memory-mapped IO.
// Ports:
//   clock/reset  - clock and synchronous active-high reset.
//   mwmem/mrmem  - store and load strobes.
//   msize        - access size (byte, half, word).
//   munsigned    - zero-extend loads when set.
//   malu/mb      - effective address and store data.
//   in_port      - asynchronous input pins.
//   mmo          - load data.
//   out_port     - registered output ports.
//   merr         - sticky misalignment flag.
module pipemem_io_gen #(
  parameter int DMEM_AW = 5,
  parameter int N_OUT   = 6,
  parameter int N_IN    = 2,
  parameter int IN_W    = 4,
  parameter int IO_BIT  = 7
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   mwmem,
  input  logic                   mrmem,
  input  logic [1:0]             msize,
  input  logic                   munsigned,
  input  logic [31:0]            malu,
  input  logic [31:0]            mb,
  input  logic [N_IN*IN_W-1:0]   in_port,
  output logic [31:0]            mmo,
  output logic [N_OUT*32-1:0]    out_port,
  output logic                   merr
);

  localparam int DW = 2 ** DMEM_AW;

  logic [31:0]          mem_q [DW];
  logic [31:0]          out_q [N_OUT];
  logic [N_IN*IN_W-1:0] s1_q, s2_q;
  logic [15:0]          chg_q, chg_d;
  logic                 merr_q, merr_d;

  logic [1:0]         lane;
  logic [4:0]         r;
  logic               is_io;
  logic [DMEM_AW-1:0] widx;
  logic               aligned;
  logic [3:0]         be;
  logic [31:0]        raw, sh, wdata, merged, status;
  logic               st, rd_stat;
  logic               unused_ok;

  assign lane      = malu[1:0];
  assign r         = malu[6:2];
  assign is_io     = malu[IO_BIT];
  assign widx      = malu[DMEM_AW+1:2];
  assign status    = {merr_q, 15'b0, chg_q};
  assign st        = mwmem & aligned;
  assign rd_stat   = mrmem & aligned & is_io & (r == 5'd31);
  assign unused_ok = ^malu;

  always_comb begin
    aligned = 1'b1;
    be      = 4'hF;
    wdata   = mb;
    unique case (msize)
      2'b00: begin
        be    = 4'b0001 << lane;
        wdata = {4{mb[7:0]}};
      end
      2'b01: begin
        aligned = ~lane[0];
        be      = lane[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{mb[15:0]}};
      end
      default: aligned = (lane == 2'b00);
    endcase
  end

  // Whole-word view of the addressed location.
  always_comb begin
    raw = '0;
    if (!is_io) begin
      raw = mem_q[widx];
    end else if (r == 5'd31) begin
      raw = status;
    end else begin
      for (int k = 0; k < N_OUT; k++)
        if (r == 5'(k)) raw = out_q[k];
      for (int k = 0; k < N_IN; k++)
        if (r == 5'(16 + k))
          raw[IN_W-1:0] = s2_q[k*IN_W +: IN_W];
    end
  end

  // Aligned accesses only ever need a shift by the lane.
  always_comb begin
    sh = raw >> {lane, 3'b000};
    unique case (msize)
      2'b00: mmo = munsigned ? {24'b0, sh[7:0]}
                             : {{24{sh[7]}}, sh[7:0]};
      2'b01: mmo = munsigned ? {16'b0, sh[15:0]}
                             : {{16{sh[15]}}, sh[15:0]};
      default: mmo = sh;
    endcase
    if (!aligned) mmo = '0;
  end

  always_comb begin
    merged = raw;
    for (int i = 0; i < 4; i++)
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
  end

  // Set beats clear-on-read on the same edge.
  always_comb begin
    chg_d  = rd_stat ? 16'h0 : chg_q;
    merr_d = rd_stat ? 1'b0 : merr_q;
    for (int k = 0; k < N_IN; k++)
      if (s1_q[k*IN_W +: IN_W] != s2_q[k*IN_W +: IN_W])
        chg_d[k] = 1'b1;
    if ((mwmem | mrmem) & ~aligned) merr_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset && st && !is_io) mem_q[widx] <= merged;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < N_OUT; k++) out_q[k] <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      chg_q  <= '0;
      merr_q <= 1'b0;
    end else begin
      s1_q   <= in_port;
      s2_q   <= s1_q;
      chg_q  <= chg_d;
      merr_q <= merr_d;
      for (int k = 0; k < N_OUT; k++)
        if (st && is_io && r == 5'(k)) out_q[k] <= merged;
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_out
    assign out_port[g*32 +: 32] = out_q[g];
  end

  assign merr = merr_q;

endmodule

// File: tb/tb_pipemem_io_gen.sv
// Testbench for pipemem_io_gen.
// Byte-level reference model plus directed and random scenarios.
module tb_pipemem_io_gen;

  logic         clock = 1'b0;
  logic         reset, mwmem, mrmem, munsigned;
  logic [1:0]   msize;
  logic [31:0]  malu, mb, mmo;
  logic [7:0]   in_port;
  logic [191:0] out_port;
  logic         merr;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ram_b [128];
  logic [7:0]  out_b [24];
  logic [7:0]  s1m, s2m, pins;
  logic [15:0] m_chg;
  logic        m_merr;
  logic [31:0] last_mmo;

  pipemem_io_gen dut (
    .clock(clock), .reset(reset), .mwmem(mwmem), .mrmem(mrmem),
    .msize(msize), .munsigned(munsigned), .malu(malu), .mb(mb),
    .in_port(in_port), .mmo(mmo), .out_port(out_port), .merr(merr)
  );

  always #5 clock = ~clock;

  function automatic int nbytes(input logic [1:0] sz);
    if (sz == 2'd0) return 1;
    if (sz == 2'd1) return 2;
    return 4;
  endfunction

  function automatic bit m_aligned(input logic [1:0] sz,
                                   input logic [31:0] a);
    return (a % nbytes(sz)) == 0;
  endfunction

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    int r;
    logic [31:0] w;
    r = int'(a[6:2]);
    w = 0;
    if (!a[7]) return ram_b[a[6:0]];
    if (r < 6) return out_b[r*4 + int'(a[1:0])];
    if (r == 16) w = {28'b0, s2m[3:0]};
    if (r == 17) w = {28'b0, s2m[7:4]};
    if (r == 31) w = {m_merr, 15'b0, m_chg};
    return w[8*a[1:0] +: 8];
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz,
                                         input bit uns,
                                         input logic [31:0] a);
    logic [31:0] v;
    int n;
    n = nbytes(sz);
    if (!m_aligned(sz, a)) return 0;
    v = 0;
    for (int i = 0; i < n; i++)
      v = v | (32'(byte_at(a + 32'(i))) << (8*i));
    if (n < 4 && !uns && v[8*n-1])
      v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 24; i++) out_b[i] = 8'h0;
    s1m = 0; s2m = 0; m_chg = 0; m_merr = 0;
  endtask

  task automatic m_edge(input bit we, input bit re,
                        input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d, input logic [7:0] p,
                        input bit rst);
    bit al, rd;
    logic [31:0] b;
    logic [15:0] nc;
    logic nm;
    int r;
    if (rst) begin
      m_reset();
      return;
    end
    al = m_aligned(sz, a);
    r  = int'(a[6:2]);
    rd = re && al && a[7] && r == 31;
    nm = rd ? 1'b0 : m_merr;
    if ((we || re) && !al) nm = 1'b1;
    nc = rd ? 16'h0 : m_chg;
    if (s1m[3:0] != s2m[3:0]) nc[0] = 1'b1;
    if (s1m[7:4] != s2m[7:4]) nc[1] = 1'b1;
    if (we && al)
      for (int i = 0; i < nbytes(sz); i++) begin
        b = a + 32'(i);
        if (!b[7]) ram_b[b[6:0]] = d[8*i +: 8];
        else if (r < 6) out_b[r*4 + int'(b[1:0])] = d[8*i +: 8];
      end
    s2m = s1m; s1m = p; m_chg = nc; m_merr = nm;
  endtask

  task automatic cyc(input bit we, input bit re,
                     input logic [1:0] sz, input bit uns,
                     input logic [31:0] a, input logic [31:0] d,
                     input bit rst);
    logic [31:0]  exp;
    logic [191:0] eo;
    reset = rst; mwmem = we; mrmem = re; msize = sz;
    munsigned = uns; malu = a; mb = d; in_port = pins;
    exp = m_load(sz, uns, a);
    @(negedge clock);
    last_mmo = mmo;
    if (re && !we && !rst) begin
      checks++;
      if (mmo !== exp) begin
        errors++;
        $display("FAIL mmo a=%h sz=%0d got %h want %h",
                 a, sz, mmo, exp);
      end
    end
    @(posedge clock);
    m_edge(we, re, sz, a, d, pins, rst);
    #1;
    for (int k = 0; k < 6; k++)
      eo[k*32 +: 32] = {out_b[4*k+3], out_b[4*k+2],
                        out_b[4*k+1], out_b[4*k]};
    checks++;
    if (out_port !== eo) begin
      errors++;
      $display("FAIL out_port got %h want %h", out_port, eo);
    end
    checks++;
    if (merr !== m_merr) begin
      errors++;
      $display("FAIL merr got %b want %b", merr, m_merr);
    end
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] d);
    cyc(1, 0, 2'd2, 0, a, d, 0);
  endtask
  task automatic st(input logic [1:0] sz, input logic [31:0] a,
                    input logic [31:0] d);
    cyc(1, 0, sz, 0, a, d, 0);
  endtask
  task automatic ld(input logic [1:0] sz, input bit uns,
                    input logic [31:0] a);
    cyc(0, 1, sz, uns, a, 0, 0);
  endtask
  task automatic nop();
    cyc(0, 0, 2'd2, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    cyc(0, 0, 2'd2, 0, 0, 0, 1);
    ld(2'd2, 0, 32'hFC);
    checks++;
    if (last_mmo !== 32'h0) begin
      errors++;
      $display("FAIL reset_status got %h want 0", last_mmo);
    end
  endtask

  task automatic test_ram_word();
    sw(32'h04, 32'hDEADBEEF);
    ld(2'd2, 0, 32'h04);
    checks++;
    if (last_mmo !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL lw04 got %h want deadbeef", last_mmo);
    end
  endtask

  task automatic test_byte_half();
    sw(32'h08, 32'h11223344);
    st(2'd0, 32'h0A, 32'h000000AB);
    ld(2'd0, 0, 32'h0A);
    checks++;
    if (last_mmo !== 32'hFFFFFFAB) begin
      errors++;
      $display("FAIL lb0A got %h want ffffffab", last_mmo);
    end
    ld(2'd0, 1, 32'h0A);
    checks++;
    if (last_mmo !== 32'h000000AB) begin
      errors++;
      $display("FAIL lbu0A got %h want 000000ab", last_mmo);
    end
    ld(2'd2, 0, 32'h08);
    checks++;
    if (last_mmo !== 32'h11AB3344) begin
      errors++;
      $display("FAIL lw08 got %h want 11ab3344", last_mmo);
    end
  endtask

  task automatic test_misalign();
    st(2'd1, 32'h81, 32'h1234);
    checks++;
    if (merr !== 1'b1 || out_port[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL mis_sh merr %b out0 %h want 1 0",
               merr, out_port[31:0]);
    end
    ld(2'd2, 0, 32'hFC);
    checks++;
    if (last_mmo[31] !== 1'b1) begin
      errors++;
      $display("FAIL status_merr got %h want bit31", last_mmo);
    end
    ld(2'd2, 0, 32'hFC);
    checks++;
    if (last_mmo !== 32'h0) begin
      errors++;
      $display("FAIL status_clr got %h want 0", last_mmo);
    end
  endtask

  task automatic test_io_out();
    sw(32'h94, 32'h55);
    checks++;
    if (out_port[5*32 +: 32] !== 32'h55) begin
      errors++;
      $display("FAIL out5 got %h want 55", out_port[5*32 +: 32]);
    end
    ld(2'd2, 0, 32'h94);
    checks++;
    if (last_mmo !== 32'h55) begin
      errors++;
      $display("FAIL rd_out5 got %h want 55", last_mmo);
    end
    sw(32'hC0, 32'hFFFF);
    checks++;
    if (merr !== 1'b0) begin
      errors++;
      $display("FAIL st_in merr got %b want 0", merr);
    end
  endtask

  task automatic test_input_sync();
    pins = 8'h0A;
    ld(2'd2, 0, 32'hC0);
    ld(2'd2, 0, 32'hC0);
    checks++;
    if (last_mmo !== 32'h0) begin
      errors++;
      $display("FAIL sync_c1 got %h want 0", last_mmo);
    end
    ld(2'd2, 0, 32'hC0);
    checks++;
    if (last_mmo !== 32'hA) begin
      errors++;
      $display("FAIL sync_c2 got %h want a", last_mmo);
    end
    ld(2'd2, 0, 32'hFC);
    checks++;
    if (last_mmo !== 32'h1) begin
      errors++;
      $display("FAIL chg_set got %h want 1", last_mmo);
    end
    pins = 8'h05;
    nop();
    ld(2'd2, 0, 32'hFC);
    ld(2'd2, 0, 32'hFC);
    checks++;
    if (last_mmo !== 32'h1) begin
      errors++;
      $display("FAIL chg_win got %h want 1", last_mmo);
    end
    ld(2'd2, 0, 32'hFC);
    checks++;
    if (last_mmo !== 32'h0) begin
      errors++;
      $display("FAIL chg_clr got %h want 0", last_mmo);
    end
  endtask

  task automatic test_reset_mid();
    sw(32'h00, 32'hCAFE0001);
    sw(32'h80, 32'h77);
    ld(2'd2, 0, 32'h02);
    pins = 8'h30;
    nop();
    nop();
    cyc(1, 0, 2'd2, 0, 32'h80, 32'hFF, 1);
    checks++;
    if (out_port !== '0 || merr !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid out %h merr %b want 0",
               out_port, merr);
    end
    ld(2'd2, 0, 32'hFC);
    checks++;
    if (last_mmo !== 32'h0) begin
      errors++;
      $display("FAIL rst_status got %h want 0", last_mmo);
    end
    ld(2'd2, 0, 32'h00);
    checks++;
    if (last_mmo !== 32'hCAFE0001) begin
      errors++;
      $display("FAIL rst_ram got %h want cafe0001", last_mmo);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [4:0]  rs [9];
    int op;
    logic [1:0] sz;
    rs = '{0, 1, 2, 3, 4, 5, 16, 17, 31};
    for (int w = 0; w < 32; w++) sw(32'(w*4), $urandom);
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(7) == 0) pins = 8'($urandom);
      sz = 2'($urandom_range(3));
      if ($urandom_range(1) == 0)
        a = {25'b0, 7'($urandom)};
      else if ($urandom_range(3) == 0)
        a = {24'b0, 1'b1, 5'($urandom), 2'($urandom)};
      else
        a = {24'b0, 1'b1, rs[$urandom_range(8)], 2'($urandom)};
      if ($urandom_range(3) != 0)
        a = a & ~(32'(nbytes(sz)) - 1);
      op = $urandom_range(2);
      cyc(op == 1, op == 2, sz, 1'($urandom), a, $urandom, 0);
    end
  endtask

  initial begin
    reset = 1; mwmem = 0; mrmem = 0; msize = 0; munsigned = 0;
    malu = 0; mb = 0; pins = 0; in_port = 0;
    for (int i = 0; i < 128; i++) ram_b[i] = 8'h0;
    m_reset();
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    test_ram_word();
    test_byte_half();
    test_misalign();
    test_io_out();
    test_input_sync();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
